// File: rtl/lsu_mem_ctrl_if.sv
// Request/response bus between the execute stage and the load/store unit.
// Member names follow the LSU's own view (i_ = into the LSU, o_ = out of it).
interface lsu_mem_ctrl_if;
  logic        i_req_vld;
  logic        o_req_rdy;
  logic        i_wren;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic        o_rsp_vld;
  logic [31:0] o_ld_data;
  logic        o_rsp_err;

  modport master (
    output i_req_vld, i_wren, i_funct3, i_addr, i_st_data,
    input  o_req_rdy, o_rsp_vld, o_ld_data, o_rsp_err
  );

  modport slave (
    input  i_req_vld, i_wren, i_funct3, i_addr, i_st_data,
    output o_req_rdy, o_rsp_vld, o_ld_data, o_rsp_err
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: byte-enabled data memory with configurable read latency,
// output peripheral registers and synchronised input peripheral words.
module lsu_mem_ctrl #(
  parameter int unsigned DMEM_DEPTH = 2048,
  parameter logic [31:0] DMEM_BASE  = 32'h0000_2000,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned N_OUT      = 16,
  parameter logic [31:0] OUT_BASE   = 32'h0000_7000,
  parameter int unsigned N_IN       = 8,
  parameter logic [31:0] IN_BASE    = 32'h0000_7800
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  lsu_mem_ctrl_if.slave        bus,
  input  logic [32*N_IN-1:0]   i_in_periph,
  output logic [32*N_OUT-1:0]  o_out_periph
);
  localparam int AW = $clog2(DMEM_DEPTH);
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [29:0] DM_LO  = DMEM_BASE[31:2];
  localparam logic [29:0] DM_HI  = DM_LO + 30'(DMEM_DEPTH);
  localparam logic [29:0] OUT_LO = OUT_BASE[31:2];
  localparam logic [29:0] OUT_HI = OUT_LO + 30'(N_OUT);
  localparam logic [29:0] IN_LO  = IN_BASE[31:2];
  localparam logic [29:0] IN_HI  = IN_LO + 30'(N_IN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] CNT_LAST = 2'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

  function automatic logic [31:0] f_extract(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  f_extract = {{24{sh[7]}}, sh[7:0]};
      3'b001:  f_extract = {{16{sh[15]}}, sh[15:0]};
      3'b100:  f_extract = {24'd0, sh[7:0]};
      3'b101:  f_extract = {16'd0, sh[15:0]};
      default: f_extract = sh;
    endcase
  endfunction

  logic [1:0]  r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_ld_data;
  logic        r_err;
  logic        r_src_mem;
  logic [1:0]  r_lane;
  logic [2:0]  r_f3;
  logic [31:0] r_mem_q;
  logic [31:0] r_dmem [DMEM_DEPTH];
  logic [31:0] r_out  [N_OUT];
  logic [32*N_IN-1:0] r_sync1, r_sync2;

  logic [29:0]   w_word;
  logic [1:0]    w_lane;
  logic          w_dm_hit, w_out_hit, w_in_hit;
  logic [AW-1:0] w_dm_idx;
  logic [OW-1:0] w_out_idx;
  logic [IW-1:0] w_in_idx;
  logic          w_illegal, w_misal, w_err;
  logic [3:0]    w_be;
  logic [31:0]   w_st_lanes;
  logic          w_accept, w_st_ok, w_ld_mem;
  logic [31:0]   w_in_word;
  logic [31:0]   w_ld_imm;

  assign w_word    = bus.i_addr[31:2];
  assign w_lane    = bus.i_addr[1:0];
  assign w_dm_hit  = (w_word >= DM_LO)  && (w_word < DM_HI);
  assign w_out_hit = (w_word >= OUT_LO) && (w_word < OUT_HI);
  assign w_in_hit  = (w_word >= IN_LO)  && (w_word < IN_HI);
  assign w_dm_idx  = bus.i_addr[2 +: AW];
  assign w_out_idx = OW'(w_word - OUT_LO);
  assign w_in_idx  = IW'(w_word - IN_LO);

  // Stores only have B/H/W; the unsigned encodings are load-only.
  assign w_illegal = (bus.i_funct3 == 3'b011) || (bus.i_funct3[2:1] == 2'b11)
                   || (bus.i_wren && bus.i_funct3[2]);
  assign w_misal   = ((bus.i_funct3[1:0] == 2'b01) && w_lane[0])
                   || ((bus.i_funct3[1:0] == 2'b10) && (w_lane != 2'b00));
  assign w_err     = w_illegal || w_misal;

  always_comb begin
    w_be = 4'b1111;
    case (bus.i_funct3[1:0])
      2'b00:   w_be = 4'b0001 << w_lane;
      2'b01:   w_be = 4'b0011 << w_lane;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_st_lanes = bus.i_st_data << {w_lane, 3'b000};
  assign w_accept   = bus.i_req_vld && (r_state == S_IDLE);
  assign w_st_ok    = w_accept && bus.i_wren && !w_err;
  assign w_ld_mem   = !bus.i_wren && !w_err && w_dm_hit;
  assign w_in_word  = r_sync2[w_in_idx*32 +: 32];

  always_comb begin
    w_ld_imm = '0;
    if (!bus.i_wren && !w_err) begin
      if (w_out_hit)
        w_ld_imm = f_extract(r_out[w_out_idx], w_lane, bus.i_funct3);
      else if (w_in_hit)
        w_ld_imm = f_extract(w_in_word, w_lane, bus.i_funct3);
    end
  end

  // Block RAM: byte-lane writes and a registered read, both on the acceptance edge.
  always_ff @(posedge i_clk) begin
    if (w_st_ok && w_dm_hit) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_dmem[w_dm_idx][b*8 +: 8] <= w_st_lanes[b*8 +: 8];
    end
    if (w_accept && w_ld_mem)
      r_mem_q <= r_dmem[w_dm_idx];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_OUT; k++) r_out[k] <= '0;
    end else if (w_st_ok && w_out_hit) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_out[w_out_idx][b*8 +: 8] <= w_st_lanes[b*8 +: 8];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_in_periph;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ld_data <= '0;
      r_err     <= 1'b0;
      r_src_mem <= 1'b0;
      r_lane    <= '0;
      r_f3      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_err     <= w_err;
          r_src_mem <= w_ld_mem;
          r_lane    <= w_lane;
          r_f3      <= bus.i_funct3;
          r_ld_data <= w_ld_imm;
          r_cnt     <= '0;
          r_state   <= (w_ld_mem && (MEM_LAT > 1)) ? S_WAIT : S_RESP;
        end
        S_WAIT: begin
          if (r_cnt == CNT_LAST) r_state <= S_RESP;
          else                   r_cnt   <= r_cnt + 2'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_req_rdy = (r_state == S_IDLE);
  assign bus.o_rsp_vld = (r_state == S_RESP);
  assign bus.o_rsp_err = r_err;
  // Memory loads are formatted from the RAM output register while responding.
  assign bus.o_ld_data = ((r_state == S_RESP) && r_src_mem)
                       ? f_extract(r_mem_q, r_lane, r_f3) : r_ld_data;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      assign o_out_periph[gi*32 +: 32] = r_out[gi];
    end
  endgenerate
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomised scoreboard bench for lsu_mem_ctrl with a byte-addressed reference model.
module tb_lsu_mem_ctrl;
  localparam int unsigned DMEM_DEPTH = 2048;
  localparam logic [31:0] DMEM_BASE  = 32'h0000_2000;
  localparam int unsigned MEM_LAT    = 3;
  localparam int unsigned N_OUT      = 16;
  localparam logic [31:0] OUT_BASE   = 32'h0000_7000;
  localparam int unsigned N_IN       = 8;
  localparam logic [31:0] IN_BASE    = 32'h0000_7800;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [32*N_IN-1:0]  in_drive = '0;
  logic [32*N_OUT-1:0] out_periph;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(
    .DMEM_DEPTH(DMEM_DEPTH), .DMEM_BASE(DMEM_BASE), .MEM_LAT(MEM_LAT),
    .N_OUT(N_OUT), .OUT_BASE(OUT_BASE), .N_IN(N_IN), .IN_BASE(IN_BASE)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .i_in_periph(in_drive), .o_out_periph(out_periph)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          at;
  } exp_t;
  exp_t sb_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model: plain byte-addressed storage.
  byte unsigned m_dm[int unsigned];
  logic [7:0]   m_out [N_OUT*4];
  logic [31:0]  m_in  [N_IN];

  function automatic bit in_rng(input logic [31:0] a, input logic [31:0] base, input int unsigned nwords);
    return (a >= base) && (a < base + nwords*4);
  endfunction

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [31:0] w;
    if (in_rng(a, DMEM_BASE, DMEM_DEPTH)) return m_dm.exists(a) ? m_dm[a] : 8'h00;
    if (in_rng(a, OUT_BASE, N_OUT)) return m_out[a - OUT_BASE];
    if (in_rng(a, IN_BASE, N_IN)) begin
      w = m_in[(a - IN_BASE) / 4];
      return w[8*((a - IN_BASE) % 4) +: 8];
    end
    return 8'h00;
  endfunction

  function automatic void wr_byte(input logic [31:0] a, input logic [7:0] d);
    if (in_rng(a, DMEM_BASE, DMEM_DEPTH)) m_dm[a] = d;
    else if (in_rng(a, OUT_BASE, N_OUT)) m_out[a - OUT_BASE] = d;
  endfunction

  function automatic void model_access(input logic wr, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] data, output logic err,
                                       output bit dm_ld);
    int unsigned n;
    data = '0; dm_ld = 0;
    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3[2]);
    n = 1 << f3[1:0];
    if (!err) err = (a % n) != 0;
    if (err) return;
    if (wr) begin
      for (int k = 0; k < int'(n); k++) wr_byte(a + k, d[8*k +: 8]);
    end else begin
      for (int k = 0; k < int'(n); k++) data[8*k +: 8] = rd_byte(a + k);
      if (!f3[2] && n < 4 && data[8*n-1]) data = data | ~((32'h1 << (8*n)) - 32'h1);
      dm_ld = in_rng(a, DMEM_BASE, DMEM_DEPTH);
    end
  endfunction

  function automatic logic [32*N_OUT-1:0] out_vec();
    logic [32*N_OUT-1:0] v;
    for (int i = 0; i < N_OUT*4; i++) v[8*i +: 8] = m_out[i];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm);
    n_chk++;
    if (out_periph !== out_vec()) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, out_periph, out_vec());
    end
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ed;
    logic ee;
    bit dm;
    exp_t e;
    int g;
    @(negedge clk);
    bus.i_req_vld = 1'b1; bus.i_wren = wr; bus.i_funct3 = f3;
    bus.i_addr = a; bus.i_st_data = d;
    g = 0;
    while (!bus.o_req_rdy && g < 50) begin @(negedge clk); g++; end
    if (!bus.o_req_rdy) begin
      n_chk++; n_fail++;
      $display("FAIL rdy_timeout: o_req_rdy stuck at 0, required 1");
      bus.i_req_vld = 1'b0;
      return;
    end
    model_access(wr, f3, a, d, ed, ee, dm);
    e.data = ed; e.err = ee;
    e.at = cyc + 1 + (dm ? int'(MEM_LAT) - 1 : 0);
    sb_q.push_back(e);
    $display("req wr=%0d f3=%0d addr=%h data=%h -> exp ld=%h err=%0d", wr, f3, a, d, ed, ee);
    @(negedge clk);
    bus.i_req_vld = 1'b0;
    if (wr) chk_out("out_periph_after_store");
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() > 0 && g < 100) begin @(negedge clk); g++; end
    if (sb_q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_timeout: %0d responses missing, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: every response pulse is checked against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.o_rsp_vld) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_vld=1 at cyc %0d data=%h, required no response", cyc, bus.o_ld_data);
      end else begin
        e = sb_q.pop_front();
        if (bus.o_ld_data !== e.data || bus.o_rsp_err !== e.err || cyc != e.at) begin
          n_fail++;
          $display("FAIL rsp: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d",
                   bus.o_ld_data, bus.o_rsp_err, cyc, e.data, e.err, e.at);
        end
      end
    end
  end

  initial begin
    logic [31:0] um [5];
    logic [2:0]  f3s [11];
    logic [31:0] a;
    int acc, nrsp;
    um  = '{32'h0000_9000, 32'h0000_4000, 32'h0000_1FFC, 32'h0000_7040, 32'h0000_7820};
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < N_OUT*4; i++) m_out[i] = 8'h00;
    for (int i = 0; i < N_IN; i++) m_in[i] = '0;
    bus.i_req_vld = 1'b0; bus.i_wren = 1'b0; bus.i_funct3 = '0;
    bus.i_addr = '0; bus.i_st_data = '0;

    repeat (3) @(negedge clk);
    chk("reset_rdy", 32'(bus.o_req_rdy), 32'd1);
    chk("reset_rsp_vld", 32'(bus.o_rsp_vld), 32'd0);
    chk("reset_ld_data", bus.o_ld_data, 32'd0);
    chk("reset_err", 32'(bus.o_rsp_err), 32'd0);
    chk_out("reset_out_periph");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) issue(1, 3'd2, DMEM_BASE + 4*i, $urandom());

    issue(1, 3'd2, 32'h2004, 32'hDEAD_BEEF);
    issue(0, 3'd2, 32'h2004, 32'h0);
    issue(1, 3'd2, 32'h2010, 32'h0);
    issue(1, 3'd0, 32'h2012, 32'h80);
    issue(0, 3'd0, 32'h2012, 32'h0);
    issue(0, 3'd4, 32'h2012, 32'h0);
    issue(0, 3'd2, 32'h2010, 32'h0);
    issue(1, 3'd1, 32'h7006, 32'h0000_ABCD);
    chk("out_periph1_sh", out_periph[32 +: 32], 32'hABCD_0000);
    issue(0, 3'd5, 32'h7006, 32'h0);
    issue(1, 3'd2, 32'h3FFC, 32'h1357_9BDF);
    issue(0, 3'd2, 32'h3FFC, 32'h0);
    issue(0, 3'd2, 32'h4000, 32'h0);
    issue(1, 3'd2, 32'h703C, 32'h2468_ACE0);
    issue(0, 3'd1, 32'h703E, 32'h0);
    issue(1, 3'd2, 32'h7040, 32'hFFFF_FFFF);

    in_drive[64 +: 32] = 32'h1234_5678;
    in_drive[224 +: 32] = 32'h8765_4321;
    repeat (3) @(negedge clk);
    m_in[2] = 32'h1234_5678; m_in[7] = 32'h8765_4321;
    issue(0, 3'd2, 32'h7808, 32'h0);
    issue(0, 3'd0, 32'h781F, 32'h0);
    issue(1, 3'd2, 32'h7808, 32'hFFFF_0000);
    repeat (2) @(negedge clk);
    in_drive[64 +: 32] = 32'hCAFE_F00D;
    issue(0, 3'd2, 32'h7808, 32'h0);
    repeat (3) @(negedge clk);
    m_in[2] = 32'hCAFE_F00D;
    issue(0, 3'd2, 32'h7808, 32'h0);

    issue(0, 3'd2, 32'h2002, 32'h0);
    issue(1, 3'd1, 32'h7001, 32'h5555);
    issue(0, 3'd2, 32'h2000, 32'h0);
    issue(0, 3'd2, 32'h7000, 32'h0);
    issue(0, 3'd2, 32'h9000, 32'h0);
    issue(0, 3'd3, 32'h2000, 32'h0);
    issue(1, 3'd4, 32'h2000, 32'h0);
    drain();

    // Held request: accepts alternate with response cycles.
    @(negedge clk);
    bus.i_req_vld = 1'b1; bus.i_wren = 1'b0; bus.i_funct3 = 3'd2; bus.i_addr = 32'h9000;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_req_rdy) begin
        exp_t e;
        acc++;
        e.data = '0; e.err = 1'b0; e.at = cyc + 1;
        sb_q.push_back(e);
      end
      @(negedge clk);
    end
    bus.i_req_vld = 1'b0;
    chk("held_vld_accepts", 32'(acc), 32'd3);
    drain();

    // Reset while a memory load sits in WAIT.
    issue(1, 3'd2, 32'h7010, 32'hA5A5_5A5A);
    drain();
    @(negedge clk);
    bus.i_req_vld = 1'b1; bus.i_wren = 1'b0; bus.i_funct3 = 3'd2; bus.i_addr = 32'h2004;
    @(negedge clk);
    bus.i_req_vld = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midwait_rst_rdy", 32'(bus.o_req_rdy), 32'd1);
    chk("midwait_rst_rsp_vld", 32'(bus.o_rsp_vld), 32'd0);
    for (int i = 0; i < N_OUT*4; i++) m_out[i] = 8'h00;
    chk_out("midwait_rst_out_periph");
    @(negedge clk);
    rst_n = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (bus.o_rsp_vld) nrsp++; end
    chk("post_rst_no_rsp", 32'(nrsp), 32'd0);

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 4))
        0, 1:    a = DMEM_BASE + $urandom_range(0, 63);
        2:       a = OUT_BASE + $urandom_range(0, 63);
        3:       a = IN_BASE + $urandom_range(0, 31);
        default: a = um[$urandom_range(0, 4)] + $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 9) == 0) begin
        in_drive[32*$urandom_range(0, N_IN-1) +: 32] = $urandom();
        repeat (3) @(negedge clk);
        for (int i = 0; i < N_IN; i++) m_in[i] = in_drive[32*i +: 32];
      end
      issue(1'($urandom_range(0, 1)), f3s[$urandom_range(0, 10)], a, $urandom());
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
